// File: rtl/lsu.sv
// lsu - load/store unit between the core memory stage and a word-wide data memory.
//
// Accepts one B/H/W access at a time, performs read-modify-write for sub-word
// stores, sign/zero extension for loads, and (optionally) splits word-crossing
// accesses into two word accesses.
//
// Configuration macro: LSU_MISALIGN_EN
//   defined   : misaligned accesses allowed; word-crossing ones use RD1/WR1
//   undefined : misaligned H/HU/W are rejected with resp_err, RD1/WR1 absent
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_funct3       store flag, access type (B/H/W/BU/HU)
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data (0 for stores/errors), reject flag
//   mem_read, mem_write      word memory strobes (write commits on rising edge)
//   mem_addr, mem_wdata      word-aligned byte address, merged write word
//   mem_rdata                combinational memory read data
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | ready for a request
// RD0   | read the low word
// WR0   | write the (merged) low word
// RD1   | read the high word (low word + 4, wraps)
// WR1   | write the (merged) high word
// RESP  | resp_valid pulse
module lsu #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    WR0,
`ifdef LSU_MISALIGN_EN
    RD1,
    WR1,
`endif
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
`ifdef LSU_MISALIGN_EN
  logic [31:0] rdata1_q, rdata1_d;
`endif

  logic        accept;
  logic        bad_f3;
  logic        req_err;
  logic [31:0] lo_addr;
  logic [3:0]  be_base;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic [31:0] wr_lo;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // 011, 110, 111 are undefined; BU/HU are load-only.
  assign bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_EN
  assign req_err = bad_f3;
`else
  logic misalign;
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err  = bad_f3 || misalign;
`endif

  assign lo_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DMEM_WORDS - 1);

  logic [2:0]    size_bytes;
  logic          cross;
  logic [AW-1:0] lo_idx;
  logic [31:0]   hi_addr;
  logic [63:0]   ld_win;
  logic [7:0]    st_be;
  logic [63:0]   st_data;
  logic [31:0]   wr_hi;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  end

  // Access spills into the next word when offset + size exceeds 4 bytes.
  assign cross  = ({1'b0, addr_q[1:0]} + size_bytes) > 3'd4;
  assign lo_idx = addr_q[AW+1:2];

  // High word index wraps modulo the memory depth, also for non-power-of-2 depths.
  always_comb begin
    hi_addr = lo_addr;
    hi_addr[AW+1:2] = (lo_idx == LAST_IDX) ? '0 : lo_idx + AW'(1);
  end

  assign ld_win  = {rdata1_q, rdata0_q};
  assign ld_word = ld_win[{addr_q[1:0], 3'b000} +: 32];
  assign st_be   = {4'b0000, be_base} << addr_q[1:0];
  assign st_data = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};

  always_comb begin
    wr_lo = rdata0_q;
    wr_hi = rdata1_q;
    for (int i = 0; i < 4; i++) begin
      if (st_be[i])   wr_lo[8*i +: 8] = st_data[8*i +: 8];
      if (st_be[4+i]) wr_hi[8*i +: 8] = st_data[32+8*i +: 8];
    end
  end
`else
  logic [3:0]  st_be;
  logic [31:0] st_data;

  assign ld_word = rdata0_q >> {addr_q[1:0], 3'b000};
  assign st_be   = be_base << addr_q[1:0];
  assign st_data = wdata_q << {addr_q[1:0], 3'b000};

  always_comb begin
    wr_lo = rdata0_q;
    for (int i = 0; i < 4; i++) begin
      if (st_be[i]) wr_lo[8*i +: 8] = st_data[8*i +: 8];
    end
  end
`endif

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
`ifdef LSU_MISALIGN_EN
    rdata1_d = rdata1_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          err_d    = req_err;
          if (req_err)
            state_d = RESP;
          // A full aligned word store needs no merge, so skip the read.
          else if (req_we && (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00))
            state_d = WR0;
          else
            state_d = RD0;
        end
      end
      RD0: begin
        rdata0_d = mem_rdata;
        if (we_q)
          state_d = WR0;
`ifdef LSU_MISALIGN_EN
        else if (cross)
          state_d = RD1;
`endif
        else
          state_d = RESP;
      end
      WR0: begin
`ifdef LSU_MISALIGN_EN
        state_d = cross ? RD1 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef LSU_MISALIGN_EN
      RD1: begin
        rdata1_d = mem_rdata;
        state_d  = we_q ? WR1 : RESP;
      end
      WR1:     state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
`ifdef LSU_MISALIGN_EN
      rdata1_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
`ifdef LSU_MISALIGN_EN
      rdata1_q <= rdata1_d;
`endif
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD0: begin
        mem_read = 1'b1;
        mem_addr = lo_addr;
      end
      WR0: begin
        mem_write = !rst;
        mem_addr  = lo_addr;
        mem_wdata = wr_lo;
      end
`ifdef LSU_MISALIGN_EN
      RD1: begin
        mem_read = 1'b1;
        mem_addr = hi_addr;
      end
      WR1: begin
        mem_write = !rst;
        mem_addr  = hi_addr;
        mem_wdata = wr_hi;
      end
`endif
      default: ;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? ld_ext : 32'h0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu #(.DMEM_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word memory with a backdoor preload port.
  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_we)          mem[bd_idx] <= bd_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int          n_rd;
  int          n_wr;
  logic [31:0] rd_addr [$];

  always @(negedge clk) begin
    if (mem_read) begin
      n_rd++;
      rd_addr.push_back(mem_addr);
    end
    if (mem_write) n_wr++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = d;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    n_rd = 0;
    n_wr = 0;
    rd_addr.delete();
    check({tag, ".ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) lat = 99;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                     input int exp_nrd, input int exp_nwr);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(tag, we, f3, a, wd, rd, er, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, {31'h0, er}, {31'h0, exp_err});
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".nrd"}, n_rd, exp_nrd);
    check({tag, ".nwr"}, n_wr, exp_nwr);
  endtask

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_addr.size()) return rd_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic saw_resp;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", req_ready, 0);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_rdata", resp_rdata, 0);
    check("rst.resp_err", resp_err, 0);
    check("rst.mem_read", mem_read, 0);
    check("rst.mem_write", mem_write, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.ready_after", req_ready, 1);

    poke(8'd16,  32'h8899_AABB);
    poke(8'd17,  32'h3322_1100);
    poke(8'd255, 32'h7766_5544);
    poke(8'd0,   32'h0302_0100);

    // Loads within one word
    run("lb43",  1'b0, 3'b000, 32'h43, 0, 32'hFFFF_FF88, 1'b0, 2, 1, 0);
    run("lbu43", 1'b0, 3'b100, 32'h43, 0, 32'h0000_0088, 1'b0, 2, 1, 0);
    run("lh42",  1'b0, 3'b001, 32'h42, 0, 32'hFFFF_8899, 1'b0, 2, 1, 0);
    run("lhu42", 1'b0, 3'b101, 32'h42, 0, 32'h0000_8899, 1'b0, 2, 1, 0);
    run("lw40",  1'b0, 3'b010, 32'h40, 0, 32'h8899_AABB, 1'b0, 2, 1, 0);
    run("lb41",  1'b0, 3'b000, 32'h41, 0, 32'hFFFF_FFAA, 1'b0, 2, 1, 0);
    run("lbu40", 1'b0, 3'b100, 32'h40, 0, 32'h0000_00BB, 1'b0, 2, 1, 0);

    // Sub-word stores (read-modify-write)
    run("sb41", 1'b1, 3'b000, 32'h41, 32'h1234_5677, 0, 1'b0, 3, 1, 1);
    check("sb41.mem", mem[16], 32'h8899_77BB);
    run("sh42", 1'b1, 3'b001, 32'h42, 32'hCAFE_1234, 0, 1'b0, 3, 1, 1);
    check("sh42.mem", mem[16], 32'h1234_77BB);
    poke(8'd16, 32'h8899_AABB);

    // Aligned word store skips the read
    run("sw44", 1'b1, 3'b010, 32'h44, 32'h5A5A_A5A5, 0, 1'b0, 2, 0, 1);
    check("sw44.mem", mem[17], 32'h5A5A_A5A5);
    poke(8'd17, 32'h3322_1100);

    // Illegal type encodings
    run("f3_011", 1'b0, 3'b011, 32'h40, 0, 0, 1'b1, 1, 0, 0);
    run("f3_111", 1'b0, 3'b111, 32'h40, 0, 0, 1'b1, 1, 0, 0);
    run("sbu",    1'b1, 3'b100, 32'h40, 32'hFF, 0, 1'b1, 1, 0, 0);
    check("sbu.mem", mem[16], 32'h8899_AABB);

`ifdef LSU_MISALIGN_EN
    run("lw43", 1'b0, 3'b010, 32'h43, 0, 32'h2211_0088, 1'b0, 3, 2, 0);
    check("lw43.addr0", rd_at(0), 32'h40);
    check("lw43.addr1", rd_at(1), 32'h44);
    run("lw42", 1'b0, 3'b010, 32'h42, 0, 32'h1100_8899, 1'b0, 3, 2, 0);
    run("lh43", 1'b0, 3'b001, 32'h43, 0, 32'h0000_0088, 1'b0, 3, 2, 0);
    run("lh41", 1'b0, 3'b001, 32'h41, 0, 32'hFFFF_99AA, 1'b0, 2, 1, 0);
    run("sh41", 1'b1, 3'b001, 32'h41, 32'h0000_BEEF, 0, 1'b0, 3, 1, 1);
    check("sh41.mem", mem[16], 32'h88BE_EFBB);
    poke(8'd16, 32'h8899_AABB);
    run("sw3fe", 1'b1, 3'b010, 32'h3FE, 32'hDDCC_BBAA, 0, 1'b0, 5, 2, 2);
    check("sw3fe.addr0", rd_at(0), 32'h3FC);
    check("sw3fe.addr1", rd_at(1), 32'h000);
    check("sw3fe.w255", mem[255], 32'hBBAA_5544);
    check("sw3fe.w0", mem[0], 32'h0302_DDCC);
`else
    run("lw43", 1'b0, 3'b010, 32'h43, 0, 0, 1'b1, 1, 0, 0);
    run("lw42", 1'b0, 3'b010, 32'h42, 0, 0, 1'b1, 1, 0, 0);
    run("lh41", 1'b0, 3'b001, 32'h41, 0, 0, 1'b1, 1, 0, 0);
    run("sh41", 1'b1, 3'b001, 32'h41, 32'h0000_BEEF, 0, 1'b1, 1, 0, 0);
    check("sh41.mem", mem[16], 32'h8899_AABB);
    run("sw3fe", 1'b1, 3'b010, 32'h3FE, 32'hDDCC_BBAA, 0, 1'b1, 1, 0, 0);
    check("sw3fe.w255", mem[255], 32'h7766_5544);
    check("sw3fe.w0", mem[0], 32'h0302_0100);
`endif

    // Reset during the WR0 cycle of an aligned word store
    @(negedge clk);
    n_wr       = 0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstwr.wr0_strobe", mem_write, 1);
    rst = 1'b1;
    #1;
    check("rstwr.gated", mem_write, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) saw_resp = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) check("rstwr.ready", req_ready, 1);
    end
    check("rstwr.no_resp", {31'h0, saw_resp}, 0);
    check("rstwr.nwr", n_wr, 0);
    check("rstwr.mem", mem[16], 32'h8899_AABB);

    // Unit still works after the aborted store
    run("post_lw", 1'b0, 3'b010, 32'h40, 0, 32'h8899_AABB, 1'b0, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
